stream_mux_arb: RTL and testbench

Parametrised N-channel streaming multiplexer with a valid/ready handshake, hardware arbitration and one registered output stage. It is the sequential successor of the plain 2-to-1 select mux in the ALU datapath. It merges several operand/result producers onto one downstream ALU input port without dropping or duplicating words. It also reports which channel each output word came from.

---
 rtl/stream_mux_arb.sv | 57 +++++
 tb/tb_stream_mux_arb.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_arb.sv
// stream_mux_arb: N-channel valid/ready stream mux with arbitration and one registered output stage.
// Define STREAM_MUX_ARB_RR_EN for round-robin arbitration; fixed lowest-index priority otherwise.
module stream_mux_arb #(
    parameter int NUM_CH = 4,
    parameter int WIDTH = 8,
    localparam int SEL_W = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       in_valid,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    output logic [NUM_CH-1:0]       in_ready,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    input  logic                    out_ready
);
    logic [SEL_W-1:0] g;
    logic [SEL_W-1:0] last;
    logic take;
    // rst_n gating keeps producers from seeing a grant that the reset will discard
    assign take = rst_n && (!out_valid || out_ready) && |in_valid;
`ifdef STREAM_MUX_ARB_RR_EN
    always_comb begin
        g = '0;
        for (int k = NUM_CH; k >= 1; k--)
            if (in_valid[(int'(last) + k) % NUM_CH]) g = SEL_W'((int'(last) + k) % NUM_CH);
    end
`else
    logic unused_last;
    assign unused_last = ^last;
    always_comb begin
        g = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (in_valid[i]) g = SEL_W'(i);
    end
`endif
    always_comb begin
        in_ready = '0;
        in_ready[g] = take;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data <= '0;
            out_sel <= '0;
            last <= SEL_W'(NUM_CH - 1);
        end else if (take) begin
            out_valid <= 1'b1;
            out_data <= in_data[int'(g) * WIDTH +: WIDTH];
            out_sel <= g;
            last <= g;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_stream_mux_arb.sv
// tb_stream_mux_arb: directed and random scoreboard checks of stream_mux_arb at three sizes.
module tb_stream_mux_arb;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int act = 0;
    int n_act, w_act;
    logic [15:0] v_drv = '0;
    logic [511:0] d_drv = '0;
    logic o_rdy = 1'b0;
    logic proto_en = 1'b0;
    int n_cmp = 0;
    int n_err = 0;

    logic [3:0] v0, r0;
    logic [31:0] d0;
    logic ov0;
    logic [7:0] od0;
    logic [1:0] os0;
    logic [1:0] v1, r1;
    logic [63:0] d1;
    logic ov1;
    logic [31:0] od1;
    logic [0:0] os1;
    logic [15:0] v2, r2, d2;
    logic ov2;
    logic [0:0] od2;
    logic [3:0] os2;

    assign v0 = (act == 0) ? v_drv[3:0] : 4'd0;
    assign v1 = (act == 1) ? v_drv[1:0] : 2'd0;
    assign v2 = (act == 2) ? v_drv : 16'd0;
    assign d1 = d_drv[63:0];
    always_comb begin
        d0 = '0;
        d2 = '0;
        for (int i = 0; i < 4; i++) d0[i*8 +: 8] = d_drv[i*32 +: 8];
        for (int i = 0; i < 16; i++) d2[i] = d_drv[i*32];
    end

    stream_mux_arb #(.NUM_CH(4), .WIDTH(8)) dut0 (.clk(clk), .rst_n(rst_n), .in_valid(v0), .in_data(d0),
        .in_ready(r0), .out_valid(ov0), .out_data(od0), .out_sel(os0), .out_ready(o_rdy));
    stream_mux_arb #(.NUM_CH(2), .WIDTH(32)) dut1 (.clk(clk), .rst_n(rst_n), .in_valid(v1), .in_data(d1),
        .in_ready(r1), .out_valid(ov1), .out_data(od1), .out_sel(os1), .out_ready(o_rdy));
    stream_mux_arb #(.NUM_CH(16), .WIDTH(1)) dut2 (.clk(clk), .rst_n(rst_n), .in_valid(v2), .in_data(d2),
        .in_ready(r2), .out_valid(ov2), .out_data(od2), .out_sel(os2), .out_ready(o_rdy));

    logic [15:0] rdy;
    logic ov;
    logic [31:0] od;
    logic [3:0] os;
    logic [63:0] dm;
    always_comb begin
        n_act = (act == 0) ? 4 : (act == 1) ? 2 : 16;
        w_act = (act == 0) ? 8 : (act == 1) ? 32 : 1;
        dm = (64'd1 << w_act) - 64'd1;
        rdy = (act == 0) ? 16'(r0) : (act == 1) ? 16'(r1) : r2;
        ov = (act == 0) ? ov0 : (act == 1) ? ov1 : ov2;
        od = (act == 0) ? 32'(od0) : (act == 1) ? od1 : 32'(od2);
        os = (act == 0) ? 4'(os0) : (act == 1) ? 4'(os1) : os2;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int mgrant(input logic [15:0] v, input int n, input int last);
        for (int k = 1; k <= n; k++) begin
`ifdef STREAM_MUX_ARB_RR_EN
            int i = (last + k) % n;
`else
            int i = k - 1;
`endif
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // Reference model: expected words are queued on acceptance, popped on delivery
    logic [35:0] sbq[$];
    logic m_valid = 1'b0;
    int m_last = 3;
    int mg;
    logic mld;
    logic [35:0] me;
    logic [15:0] prev_v = '0, last_rdy = '0;
    logic [511:0] prev_d = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_valid = 1'b0;
            m_last = n_act - 1;
            sbq.delete();
            prev_v = '0;
            last_rdy = '0;
        end else begin
            mld = !m_valid || o_rdy;
            mg = mgrant(v_drv, n_act, m_last);
            if (proto_en)
                for (int i = 0; i < n_act; i++)
                    if (prev_v[i] && !last_rdy[i])
                        chk("hold", {31'd0, v_drv[i], d_drv[i*32 +: 32] & dm[31:0]},
                            {31'd0, 1'b1, prev_d[i*32 +: 32] & dm[31:0]});
            chk("in_ready", 64'(rdy), (mld && mg >= 0) ? (64'd1 << mg) : 64'd0);
            chk("out_valid", 64'(ov), 64'(m_valid));
            if (m_valid && o_rdy && sbq.size() > 0) begin
                me = sbq.pop_front();
                chk("out_sel", 64'(os), 64'(me[35:32]));
                chk("out_data", 64'(od), 64'(me[31:0]));
            end
            if (mld && mg >= 0) begin
                sbq.push_back({4'(mg), d_drv[mg*32 +: 32] & dm[31:0]});
                m_valid = 1'b1;
                m_last = mg;
            end else if (o_rdy) begin
                m_valid = 1'b0;
            end
            prev_v = v_drv;
            prev_d = d_drv;
            last_rdy = rdy;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int i, input logic [31:0] val);
        d_drv[i*32 +: 32] = val;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic rand_phase(input int cycles, input int vpct, input int rpct);
        for (int c = 0; c < cycles; c++) begin
            for (int i = 0; i < n_act; i++)
                if (!v_drv[i] || last_rdy[i]) begin
                    v_drv[i] = ($urandom_range(99) < vpct);
                    for (int b = 0; b < w_act; b++) d_drv[i*32 + b] = 1'($urandom_range(1));
                end
            o_rdy = ($urandom_range(99) < rpct);
            step();
        end
    endtask

    task automatic drain();
        int t;
        proto_en = 1'b0;
        v_drv = '0;
        o_rdy = 1'b1;
        t = 0;
        while (ov && t < 10) begin
            step();
            t++;
        end
        @(negedge clk);
        chk("drain_done", 64'(ov), 64'd0);
        chk("sb_empty", 64'(sbq.size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] words [3];
        int es;
        words[0] = 8'h11;
        words[1] = 8'h22;
        words[2] = 8'h33;
        // Reset with all channels requesting and downstream ready
        act = 0;
        rst_n = 1'b0;
        v_drv = 16'h000F;
        for (int i = 0; i < 4; i++) set_ch(i, 32'h10 + 32'(i));
        o_rdy = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 64'(ov0), 64'd0);
        chk("rst_in_ready", 64'(r0), 64'd0);
        chk("rst_out_data", 64'(od0), 64'd0);
        chk("rst_out_sel", 64'(os0), 64'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("first_grant", 64'(r0), 64'd1);
        // Arbitration order with all four channels valid
        for (int j = 0; j < 6; j++) begin
            step();
`ifdef STREAM_MUX_ARB_RR_EN
            es = j % 4;
`else
            es = 0;
`endif
            chk("arb_sel", 64'(os0), 64'(es));
            chk("arb_data", 64'(od0), 64'h10 + 64'(es));
        end
        // Single channel streaming at one word per clock
        v_drv = 16'h0004;
        set_ch(2, 32'(words[0]));
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("single_ready", 64'(r0), 64'h4);
            step();
            chk("single_valid", 64'(ov0), 64'd1);
            chk("single_sel", 64'(os0), 64'd2);
            chk("single_data", 64'(od0), 64'(words[j]));
            if (j < 2) set_ch(2, 32'(words[j+1]));
        end
        v_drv = '0;
        step();
        chk("single_empty", 64'(ov0), 64'd0);
        // Backpressure holds 0xA5 while others wait
        v_drv = 16'h0002;
        set_ch(1, 32'hA5);
        step();
        o_rdy = 1'b0;
        v_drv = 16'h000D;
        set_ch(0, 32'h10);
        set_ch(2, 32'h12);
        set_ch(3, 32'h13);
        repeat (5) begin
            @(negedge clk);
            chk("stall_data", 64'(od0), 64'hA5);
            chk("stall_sel", 64'(os0), 64'd1);
            chk("stall_ready", 64'(r0), 64'd0);
            chk("stall_valid", 64'(ov0), 64'd1);
            step();
        end
        o_rdy = 1'b1;
        @(negedge clk);
`ifdef STREAM_MUX_ARB_RR_EN
        es = 2;
`else
        es = 0;
`endif
        chk("release_ready", 64'(r0), 64'd1 << es);
        step();
        chk("release_sel", 64'(os0), 64'(es));
        chk("release_valid", 64'(ov0), 64'd1);
        // Channels 1 and 3 contend
        v_drv = 16'h000A;
        set_ch(1, 32'h21);
        set_ch(3, 32'h23);
        for (int j = 0; j < 4; j++) begin
            step();
`ifdef STREAM_MUX_ARB_RR_EN
            es = (j % 2 == 0) ? 3 : 1;
`else
            es = 1;
`endif
            chk("prio_sel", 64'(os0), 64'(es));
            chk("prio_data", 64'(od0), 64'h20 + 64'(es));
        end
        v_drv[1] = 1'b0;
        step();
        chk("prio_after_drop", 64'(os0), 64'd3);
        drain();
        // Reset asserted while a word is stalled in the output register
        v_drv = 16'h0001;
        set_ch(0, 32'h5C);
        step();
        o_rdy = 1'b0;
        step();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", 64'(ov0), 64'd0);
        chk("midrst_ready", 64'(r0), 64'd0);
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        v_drv = '0;
        o_rdy = 1'b1;
        step();
        // Random traffic on each configuration
        for (int a = 0; a < 3; a++) begin
            v_drv = '0;
            act = a;
            reset_pulse();
            proto_en = 1'b1;
            rand_phase(400, 60, 70);
            drain();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
